pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 38 +++
 rtl/pc_ras.sv | 72 +++++++
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants and the next-pc source encoding for the program-counter sequencer.
// Imported by the sequencer top; defaults match a 32-bit MIPS-style fetch unit.
package pc_pkg;

   localparam int unsigned DefXlen        = 32;
   localparam logic [31:0] DefResetVector = 32'h0000_0000;
   localparam logic [31:0] DefExcVector   = 32'h0000_0180;
   localparam int unsigned DefRasDepth    = 4;

   typedef enum logic [2:0] {
      SEQ  = 3'd0,
      BR   = 3'd1,
      JMP  = 3'd2,
      JR   = 3'd3,
      EXC  = 3'd4,
      ERET = 3'd5
   } pc_src_e;

   // Fixed-priority decode of the control inputs into a next-pc source.
   function automatic pc_src_e pick_src(input logic exc, input logic eret, input logic jmp,
                                        input logic branch, input logic jr);
      pc_src_e src;
      src = SEQ;
      if (exc) begin
         src = EXC;
      end else if (eret) begin
         src = ERET;
      end else if (jmp) begin
         src = JMP;
      end else if (branch) begin
         src = BR;
      end else if (jr) begin
         src = JR;
      end
      return src;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored, and a simultaneous pop+push replaces the top in place.
module pc_ras #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            full
);

   localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   logic [XLEN-1:0] mem_q [RAS_DEPTH];
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] top_idx;
   logic [PtrW-1:0] wr_idx;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            wr_en;
   logic            do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CntW'(RAS_DEPTH));
   assign top_idx = wptr_q - PtrW'(1);
   assign top     = empty ? '0 : mem_q[top_idx];
   assign do_pop  = pop & ~empty;

   always_comb begin
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_idx = wptr_q;
      if (do_pop && push) begin
         // Pop then push nets out to replacing the current top.
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (do_pop) begin
         wptr_d = top_idx;
         cnt_d  = cnt_q - CntW'(1);
      end else if (push) begin
         wr_en  = 1'b1;
         wr_idx = wptr_q;
         wptr_d = wptr_q + PtrW'(1);
         if (!full) begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
         if (wr_en) begin
            mem_q[wr_idx] <= push_data;
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: single priority mux over exception, return, jump, branch,
// register-jump and sequential targets, with an exception PC and a return-address stack.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = DefXlen,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DefResetVector),
   parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DefExcVector),
   parameter int unsigned     RAS_DEPTH    = DefRasDepth
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_ready,
   input  logic            jmp,
   input  logic            branch,
   input  logic            jr,
   input  logic            call,
   input  logic [XLEN-1:0] ext_18,
   input  logic [25:0]     jmp_dest,
   input  logic [XLEN-1:0] rs,
   input  logic            exc,
   input  logic            eret,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic [XLEN-1:0] sequencial_addr,
   output logic [XLEN-1:0] epc,
   output logic [XLEN-1:0] ras_top,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            jr_mispredict
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic            valid_q;
   logic            advance;
   logic            trap;
   logic            pc_en;
   logic            ras_push;
   logic            ras_pop;
   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] jmp_target;
   pc_src_e         src;

   assign advance         = valid_q & pc_ready;
   assign trap            = exc | eret;
   assign sequencial_addr = pc_q + XLEN'(4);
   assign br_target       = sequencial_addr + ext_18;
   assign jmp_target      = {pc_q[XLEN-1:28], jmp_dest, 2'b00};

   assign pc       = pc_q;
   assign pc_valid = valid_q;
   assign epc      = epc_q;

   // Stack traffic only follows accepted fetches and never rides along with a trap.
   assign ras_push      = call & advance & ~trap;
   assign ras_pop       = jr & advance & ~trap;
   assign jr_mispredict = jr & advance & (ras_empty | (rs != ras_top));

   always_comb begin
      src   = pick_src(exc, eret, jmp, branch, jr);
      pc_en = trap | advance;
      pc_d  = pc_q;
      epc_d = epc_q;
      if (pc_en) begin
         unique case (src)
            EXC:     pc_d = EXC_VECTOR;
            ERET:    pc_d = epc_q;
            JMP:     pc_d = jmp_target;
            BR:      pc_d = br_target;
            JR:      pc_d = rs;
            default: pc_d = sequencial_addr;
         endcase
      end
      if (exc) begin
         epc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_VECTOR;
         epc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         valid_q <= 1'b1;
      end
   end

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (sequencial_addr),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random control traffic,
// compared every cycle against a queue-based behavioural model.
module tb_pc_sequencer;

   localparam int unsigned Depth = 4;

   logic        clk = 1'b0;
   logic        rst, pc_ready, jmp, branch, jr, call, exc, eret;
   logic [31:0] ext_18, rs;
   logic [25:0] jmp_dest;
   logic [31:0] pc, sequencial_addr, epc, ras_top;
   logic        pc_valid, ras_empty, ras_full, jr_mispredict;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   logic [31:0] m_pc, m_epc;
   logic        m_valid;
   logic [31:0] m_ras[$];

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk             (clk),
      .rst             (rst),
      .pc_ready        (pc_ready),
      .jmp             (jmp),
      .branch          (branch),
      .jr              (jr),
      .call            (call),
      .ext_18          (ext_18),
      .jmp_dest        (jmp_dest),
      .rs              (rs),
      .exc             (exc),
      .eret            (eret),
      .pc              (pc),
      .pc_valid        (pc_valid),
      .sequencial_addr (sequencial_addr),
      .epc             (epc),
      .ras_top         (ras_top),
      .ras_empty       (ras_empty),
      .ras_full        (ras_full),
      .jr_mispredict   (jr_mispredict)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clr();
      rst = 1'b0; pc_ready = 1'b1; jmp = 1'b0; branch = 1'b0; jr = 1'b0; call = 1'b0;
      exc = 1'b0; eret = 1'b0; ext_18 = '0; rs = '0; jmp_dest = '0;
   endtask

   function automatic logic [31:0] m_top();
      return (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
   endfunction

   // Inputs are already applied (we sit just after a negedge): check, clock, update model.
   task automatic tick();
      logic        adv;
      logic        mis;
      logic [31:0] nxt;
      #1;
      adv = m_valid & pc_ready;
      mis = jr & adv & ((m_ras.size() == 0) || (rs != m_top()));
      check("pc", pc, m_pc);
      check("pc_valid", 32'(pc_valid), 32'(m_valid));
      check("epc", epc, m_epc);
      check("seq_addr", sequencial_addr, m_pc + 32'd4);
      check("ras_top", ras_top, m_top());
      check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      check("ras_full", 32'(ras_full), 32'(m_ras.size() == Depth));
      check("jr_mispredict", 32'(jr_mispredict), 32'(mis));
      @(posedge clk);
      if (rst) begin
         m_pc = 32'h0; m_epc = 32'h0; m_valid = 1'b0;
         m_ras.delete();
      end else begin
         nxt = m_pc;
         if (exc) begin
            nxt   = 32'h180;
            m_epc = m_pc;
         end else if (eret) begin
            nxt = m_epc;
         end else if (adv) begin
            if (jmp)         nxt = {m_pc[31:28], jmp_dest, 2'b00};
            else if (branch) nxt = m_pc + 32'd4 + ext_18;
            else if (jr)     nxt = rs;
            else             nxt = m_pc + 32'd4;
            if (jr && m_ras.size() > 0) void'(m_ras.pop_back());
            if (call) begin
               m_ras.push_back(m_pc + 32'd4);
               if (m_ras.size() > Depth) void'(m_ras.pop_front());
            end
         end
         m_pc    = nxt;
         m_valid = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic call_jump(input logic [25:0] dest);
      clr(); call = 1'b1; jmp = 1'b1; jmp_dest = dest; tick();
   endtask

   initial begin
      m_pc = 32'h0; m_epc = 32'h0; m_valid = 1'b0;
      clr();
      rst = 1'b1;
      @(negedge clk);
      tick();
      tick();
      check("rst_pc", pc, 32'h0);
      check("rst_valid", 32'(pc_valid), 32'h0);

      // Sequential fetch after reset
      clr();
      repeat (4) tick();
      check("seq_pc", pc, 32'hC);

      // Jump, branch with negative offset, jump beats branch
      clr(); jmp = 1'b1; jmp_dest = 26'h40; tick();
      check("jmp_pc", pc, 32'h100);
      clr(); branch = 1'b1; ext_18 = 32'hFFFF_FFF0; tick();
      check("br_pc", pc, 32'hF4);
      clr(); branch = 1'b1; ext_18 = 32'hFFFF_FFF0; jmp = 1'b1; jmp_dest = 26'h40; tick();
      check("jmp_over_br", pc, 32'h100);

      // Stall holds, exception while stalled, return
      clr(); pc_ready = 1'b0; branch = 1'b1; ext_18 = 32'h20;
      repeat (4) tick();
      check("stall_pc", pc, 32'h100);
      exc = 1'b1; tick();
      check("exc_pc", pc, 32'h180);
      check("exc_epc", epc, 32'h100);
      clr(); eret = 1'b1; tick();
      check("eret_pc", pc, 32'h100);

      // Five calls overflow a four-entry stack
      clr(); jmp = 1'b1; jmp_dest = 26'h4; tick();
      call_jump(26'h8); call_jump(26'hC); call_jump(26'h10); call_jump(26'h14);
      call_jump(26'h18);
      check("ras_full", 32'(ras_full), 32'h1);
      check("ras_top5", ras_top, 32'h54);
      for (int i = 0; i < 4; i++) begin
         clr(); jr = 1'b1; rs = ras_top; tick();
      end
      check("pop_last", pc, 32'h24);
      check("ras_empty", 32'(ras_empty), 32'h1);

      // Mispredicts: wrong target, then empty stack
      call_jump(26'h14);
      clr(); jr = 1'b1; rs = 32'h1234; tick();
      check("jr_pc", pc, 32'h1234);
      clr(); jr = 1'b1; rs = 32'h2000; tick();
      check("jr_empty", 32'(ras_empty), 32'h1);

      // call+jr in the same cycle at 0x200 with two entries held
      call_jump(26'h40); call_jump(26'h80);
      clr(); call = 1'b1; jr = 1'b1; rs = 32'h300; tick();
      check("cj_top", ras_top, 32'h204);
      check("cj_full", 32'(ras_full), 32'h0);

      // Reset overrides concurrent exception and call
      clr(); rst = 1'b1; exc = 1'b1; call = 1'b1; tick();
      check("rst_exc_pc", pc, 32'h0);
      check("rst_exc_epc", epc, 32'h0);
      check("rst_exc_ras", 32'(ras_empty), 32'h1);

      // Random control traffic
      for (int n = 0; n < 400; n++) begin
         clr();
         rst      = ($urandom_range(0, 63) == 0);
         pc_ready = ($urandom_range(0, 3) != 0);
         jmp      = ($urandom_range(0, 7) == 0);
         branch   = ($urandom_range(0, 5) == 0);
         jr       = ($urandom_range(0, 3) == 0);
         call     = ($urandom_range(0, 2) == 0);
         exc      = ($urandom_range(0, 24) == 0);
         eret     = ($urandom_range(0, 19) == 0);
         jmp_dest = 26'($urandom);
         ext_18   = {{14{1'b0}}, 16'($urandom), 2'b00} - 32'h0002_0000;
         rs       = $urandom_range(0, 1) ? m_top() : ($urandom & 32'hFFFF_FFFC);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
